// File: rtl/irq_pkg.sv
// Shared constants, state encoding and helpers for the 32-source
// interrupt round-robin arbiter.
package irq_pkg;

  localparam int NSRC = 32;
  localparam int IDW  = 5;

  localparam logic [NSRC-1:0] MASK_RST_DFLT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  function automatic logic [NSRC-1:0] onehot(
    input logic [IDW-1:0] idx
  );
    logic [NSRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_rr_arbiter32_rr_pick32.sv
// Combinational round-robin picker: eligible/ptr in, any/winner out.
// Rotates eligible right by ptr, finds lowest set bit, adds ptr back.
module rr_pick32
  import irq_pkg::*;
(
  input  logic [NSRC-1:0] eligible,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  logic [NSRC-1:0] rot;
  logic [IDW-1:0]  k;

  // Index add is 5 bits wide, so the rotate wraps naturally.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NSRC; i++) begin
      rot[i] = eligible[IDW'(i) + ptr];
    end
  end

  // Scan high to low so the lowest set bit is the last one kept.
  always_comb begin
    k = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (rot[i]) begin
        k = IDW'(i);
      end
    end
  end

  assign any    = |eligible;
  assign winner = k + ptr;

endmodule

// File: rtl/irq_rr_arbiter32.sv
// 32-source interrupt arbiter: edge capture, mask, round-robin pick,
// req/ack handshake and end-of-service hold-off. Ports: clk, rst, irq_i,
// mask_we/mask_wdata/mask_o, pend_o, req_o/id_o/ack_i, eoi_i, busy_o.
module irq_rr_arbiter32
  import irq_pkg::*;
#(
  parameter logic [NSRC-1:0] MASK_RST = MASK_RST_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_i,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  output logic [NSRC-1:0] mask_o,
  output logic [NSRC-1:0] pend_o,
  output logic            req_o,
  output logic [IDW-1:0]  id_o,
  input  logic            ack_i,
  input  logic            eoi_i,
  output logic            busy_o
);

  state_t          state_q;
  state_t          state_d;
  logic [NSRC-1:0] irq_prev_q;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clr;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  id_d;
  logic [IDW-1:0]  winner;
  logic            req_q;
  logic            req_d;
  logic            any;
  logic            ack_hit;

  assign rise    = irq_i & ~irq_prev_q;
  assign elig    = pend_q & ~mask_q;
  assign ack_hit = (state_q == REQ) && ack_i;
  assign clr     = ack_hit ? onehot(id_q) : '0;

  rr_pick32 u_pick (
    .eligible (elig),
    .ptr      (ptr_q),
    .any      (any),
    .winner   (winner)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = REQ;
          req_d   = 1'b1;
          id_d    = winner;
        end
      end
      REQ: begin
        // ack beats a same-cycle withdraw.
        if (ack_i) begin
          state_d = SERVICE;
          req_d   = 1'b0;
          ptr_d   = id_q + IDW'(1);
        end else if (mask_q[id_q]) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      SERVICE: begin
        if (eoi_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= MASK_RST;
      ptr_q      <= '0;
      id_q       <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_i;
      // Clear first, then OR new edges: a coincident edge survives.
      pend_q     <= (pend_q & ~clr) | rise;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      req_q      <= req_d;
    end
  end

  assign mask_o = mask_q;
  assign pend_o = pend_q;
  assign req_o  = req_q;
  assign id_o   = id_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_irq_rr_arbiter32.sv
// Bench for irq_rr_arbiter32: directed scenarios then random traffic,
// checked against a scan-based reference model via a grant scoreboard.
module tb_irq_rr_arbiter32;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_SVC  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] irq_i;
  logic        mask_we;
  logic [31:0] mask_wdata;
  logic [31:0] mask_o;
  logic [31:0] pend_o;
  logic        req_o;
  logic [4:0]  id_o;
  logic        ack_i;
  logic        eoi_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  irq_rr_arbiter32 dut (
    .clk        (clk),
    .rst        (rst),
    .irq_i      (irq_i),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_o     (mask_o),
    .pend_o     (pend_o),
    .req_o      (req_o),
    .id_o       (id_o),
    .ack_i      (ack_i),
    .eoi_i      (eoi_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state kept as plain sets/ints.
  logic [31:0] m_pend;
  logic [31:0] m_prev;
  logic [31:0] m_mask;
  int          m_ptr;
  int          m_ph;
  logic        m_req;
  logic [4:0]  m_id;
  bit          model_valid = 0;
  int          exp_q[$];

  // Next grant: first eligible source scanning upward from ptr.
  function automatic int next_rr();
    logic [31:0] e;
    e = m_pend & ~m_mask;
    for (int j = 0; j < 32; j++) begin
      if (e[(m_ptr + j) % 32]) return (m_ptr + j) % 32;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [31:0] rise;
    int g;
    if (rst) begin
      m_pend = '0;
      m_prev = '0;
      m_mask = 32'hFFFF_FFFF;
      m_ptr  = 0;
      m_ph   = PH_IDLE;
      m_req  = 1'b0;
      m_id   = '0;
      exp_q.delete();
      model_valid = 1;
    end else if (model_valid) begin
      rise = irq_i & ~m_prev;
      case (m_ph)
        PH_IDLE: begin
          g = next_rr();
          if (g >= 0) begin
            m_id  = 5'(g);
            m_req = 1'b1;
            m_ph  = PH_REQ;
            exp_q.push_back(g);
          end
        end
        PH_REQ: begin
          if (ack_i) begin
            m_pend[m_id] = 1'b0;
            m_ptr = (int'(m_id) + 1) % 32;
            m_req = 1'b0;
            m_ph  = PH_SVC;
          end else if (m_mask[m_id]) begin
            m_req = 1'b0;
            m_ph  = PH_IDLE;
            void'(exp_q.pop_back());
          end
        end
        default: begin
          if (eoi_i) m_ph = PH_IDLE;
        end
      endcase
      m_pend = m_pend | rise;
      m_prev = irq_i;
      if (mask_we) m_mask = mask_wdata;
    end
  end

  // Monitor: per-cycle state compare plus grant scoreboard on handshake.
  always @(negedge clk) begin
    int e;
    if (model_valid) begin
      chk("pend", pend_o, m_pend);
      chk("mask", mask_o, m_mask);
      chk("req", 32'(req_o), 32'(m_req));
      chk("busy", 32'(busy_o), 32'(m_ph != PH_IDLE));
      chk("id", 32'(id_o), 32'(m_id));
      if (!rst && req_o && ack_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_q: got id %0d expected no grant", id_o);
        end else begin
          e = exp_q.pop_front();
          chk("grant", 32'(id_o), 32'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input string nm);
    bit got;
    got = req_o;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      got = req_o;
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  task automatic serve(input int exp_id, input string nm);
    wait_req({nm, "_req"});
    if (req_o) begin
      chk({nm, "_id"}, 32'(id_o), 32'(exp_id));
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      chk({nm, "_busy"}, 32'(busy_o), 32'd1);
      tick();
      eoi_i = 1'b1;
      tick();
      eoi_i = 1'b0;
    end
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    irq_i      = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    ack_i      = 1'b0;
    eoi_i      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_mask", mask_o, 32'hFFFF_FFFF);
    chk("rst_pend", pend_o, 32'h0);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    // Masked event only pends.
    irq_i = 32'h8;
    tick();
    irq_i = '0;
    chk("masked_pend", pend_o, 32'h8);
    tick();
    chk("masked_req", 32'(req_o), 32'd0);

    // Unmask: pending 3 is granted, then a fresh edge on 3.
    mask_we = 1'b1;
    mask_wdata = '0;
    tick();
    mask_we = 1'b0;
    serve(3, "basic");
    chk("basic_pend", pend_o, 32'h0);
    chk("basic_idle", 32'(busy_o), 32'd0);
    irq_i = 32'h8;
    tick();
    irq_i = '0;
    serve(3, "basic2");

    // Round robin with wrap.
    irq_i = (32'h1 << 5) | (32'h1 << 9) | (32'h1 << 31);
    tick();
    irq_i = '0;
    serve(5, "rr0");
    serve(9, "rr1");
    irq_i = (32'h1 << 5) | (32'h1 << 31);
    tick();
    irq_i = '0;
    serve(31, "rr2");
    serve(5, "rr3");

    // Withdraw on mask.
    irq_i = 32'h80;
    tick();
    irq_i = '0;
    wait_req("wd_req");
    chk("wd_id", 32'(id_o), 32'd7);
    mask_we = 1'b1;
    mask_wdata = 32'h80;
    tick();
    mask_we = 1'b0;
    chk("wd_hold", 32'(req_o), 32'd1);
    tick();
    chk("wd_drop", 32'(req_o), 32'd0);
    chk("wd_pend", pend_o, 32'h80);
    mask_we = 1'b1;
    mask_wdata = '0;
    tick();
    mask_we = 1'b0;
    serve(7, "wd_again");

    // Set/clear collision on id 2.
    irq_i = 32'h4;
    tick();
    irq_i = '0;
    wait_req("col_req");
    chk("col_id", 32'(id_o), 32'd2);
    ack_i = 1'b1;
    irq_i = 32'h4;
    tick();
    ack_i = 1'b0;
    irq_i = '0;
    chk("col_pend", pend_o, 32'h4);
    tick();
    eoi_i = 1'b1;
    tick();
    eoi_i = 1'b0;
    serve(2, "col_again");

    // Reset while in SERVICE with pending 0x30.
    irq_i = 32'h40;
    tick();
    irq_i = '0;
    wait_req("mr_req");
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    irq_i = 32'h30;
    tick();
    irq_i = '0;
    chk("mr_pend", pend_o, 32'h30);
    chk("mr_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_pend0", pend_o, 32'h0);
    chk("mr_req0", 32'(req_o), 32'd0);
    chk("mr_busy0", 32'(busy_o), 32'd0);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      seen += int'(req_o);
    end
    mask_we = 1'b1;
    mask_wdata = '0;
    tick();
    mask_we = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      seen += int'(req_o);
    end
    chk("mr_noreq", 32'(seen), 32'd0);
    irq_i = 32'h10;
    tick();
    irq_i = '0;
    serve(4, "mr_new");

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      tick();
      irq_i = irq_i ^ ($urandom & $urandom & $urandom);
      mask_we = ($urandom_range(0, 39) == 0);
      mask_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 :
                   ($urandom & $urandom);
      ack_i = req_o && ($urandom_range(0, 1) == 1);
      eoi_i = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 599) == 0);
    end
    irq_i = '0;
    mask_we = 1'b0;
    ack_i = 1'b0;
    eoi_i = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk("q_len", 32'(exp_q.size()), 32'(m_req));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_rr_arbiter32.md
Name: irq_rr_arbiter32

Overview:
- Sequences up to 32 interrupt/event sources onto the single 5-bit source-index path feeding the pipeline's exception logic.
- Captures rising edges into a pending register and applies a software mask.
- Picks one eligible source with round-robin fairness and presents its 5-bit id with a req/ack handshake.
- Holds off further requests until the pipeline signals end-of-service.

Parameters:
- NSRC, 32, number of sources; fixed at 32.
- IDW, 5, id width; log2(NSRC).
- MASK_RST, 32'hFFFF_FFFF, reset mask value (1 = masked).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- irq_i  in  32  raw source lines, synchronous to clk; rising edge = event.
- mask_we  in  1  mask write strobe.
- mask_wdata  in  32  new mask value (1 = masked).
- mask_o  out  32  current mask.
- pend_o  out  32  current pending bits.
- req_o  out  1  request valid to pipeline.
- id_o  out  5  index of requested source; stable while req_o=1.
- ack_i  in  1  pipeline accepts request; valid only when req_o=1.
- eoi_i  in  1  end of service for the current granted source.
- busy_o  out  1  high in REQ or SERVICE.

Behaviour:
- Reset (rst=1 at edge) takes effect that cycle regardless of state:
  - pending = 0, irq_prev = 0, mask = MASK_RST, ptr = 0, state = IDLE.
  - req_o = 0, id_o = 0, busy_o = 0.
- Edge capture:
  - edge = irq_i & ~irq_prev; irq_prev <= irq_i every cycle.
  - pending <= (pending & ~clr) | edge, where clr is the one-hot of id_o on an ack cycle.
  - If a bit's set and clear coincide, set wins: bit stays 1 as a new event.
- Mask:
  - mask <= mask_wdata on mask_we; the new value applies from the next cycle.
  - eligible = pending & ~mask, using registered values.
- Round-robin pick (combinational from eligible and ptr):
  - rot = eligible rotated right by ptr.
  - k = index of lowest set bit of rot.
  - winner = (k + ptr) mod 32, 5-bit natural wrap.
  - any = |eligible.
- FSM:
  - IDLE: if any, latch id_o <= winner, set req_o <= 1, go to REQ. Latency is one cycle from eligible becoming non-zero to req_o=1. Otherwise stay in IDLE.
  - REQ, ack_i=1: clear pending[id_o], ptr <= id_o + 1 (31 wraps to 0), req_o <= 0, go to SERVICE.
  - REQ, ack_i=0 and mask[id_o]=1: withdraw; req_o <= 0, go to IDLE. Pending bit is retained.
  - REQ, ack_i=0 otherwise: hold req_o and id_o unchanged.
  - SERVICE: wait for eoi_i=1, then go to IDLE. id_o keeps its last value. The earliest next req_o is 1 cycle after the eoi cycle.
- Handshake precedence and ignored inputs:
  - ack_i outside REQ is ignored.
  - eoi_i outside SERVICE is ignored.
  - ack_i has priority over withdraw in the same cycle.
- Outputs:
  - req_o and id_o are registered.
  - busy_o = (state != IDLE).
  - mask_o and pend_o are the register contents.
- Sources keep raising pending while the FSM is in REQ or SERVICE. No events are lost unless the same bit edges again while still pending; those coalesce.

Decomposition:
- Shared package irq_pkg holds:
  - NSRC and IDW constants.
  - State encoding: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
  - MASK_RST default.
- Sub-module rr_pick32 is purely combinational: eligible[31:0] and ptr[4:0] in, any and winner[4:0] out. It contains the rotate and the lowest-set-bit to 5-bit encode.
- The top level holds all registers and the FSM.

Test Plan:
- Reset value: after rst, mask_o=FFFF_FFFF, pend_o=0, req_o=0, busy_o=0. Pulse irq_i[3]: pend_o=0000_0008 and req_o stays 0 (masked).
- Basic request: write mask=0, raise irq_i[3]. Next cycle req_o=1 and id_o=3. ack_i -> pend_o[3]=0, busy_o=1. eoi_i -> IDLE, busy_o=0.
- Round-robin: with mask=0, set irq 5, 9 and 31 together. Grants follow 5, 9, 31. Re-raise 5 and 31 after ptr=10: next grant is 31, then 5 (wrap).
- Withdraw: raise irq 7 and hold req without ack, then mask_wdata=0000_0080. req_o drops 2 cycles after mask_we and pend_o[7] stays 1. Unmask -> req_o with id_o=7 again.
- Set/clear collision: irq_i[2] produces a new rising edge in the same cycle as ack of id 2. pend_o[2] stays 1, and a second grant of 2 follows eoi.
- Reset mid-operation: assert rst in SERVICE with pending=0000_0030. Next cycle state is IDLE, pend_o=0 and req_o=0, and no grant occurs until mask is rewritten and a new edge arrives.
